// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and runs a req/ack memory port.
// Delivers one {pc, instr} at a time to decode over a valid/ready handshake.
module fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_instr_o,
    input  logic              id_ready_i,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] target;

    assign target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        cnt_d      = cnt_q;
        if (redirect_i) begin
            pc_d    = target;
            valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = target;
                end
                HOLD: begin
                    state_d = FETCH;
                    addr_d  = target;
                    if (id_ready_i) cnt_d = cnt_q + CNT_W'(1);
                end
                FETCH, DROP: begin
                    // an outstanding request must complete before retargeting
                    if (imem_ack_i) begin
                        state_d = FETCH;
                        addr_d  = target;
                    end else begin
                        state_d = DROP;
                    end
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        if_instr_d = imem_rdata_i;
                        if_pc_d    = addr_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + ADDR_W'(4);
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (id_ready_i) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = FETCH;
                        addr_d  = pc_q;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state_d = FETCH;
                        addr_d  = pc_q;
                    end
                end
            endcase
        end
        req_d = (state_d == FETCH) || (state_d == DROP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign if_valid_o  = valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory responder with programmable wait,
// decode-side monitor, and a second instance with a wrapping reset PC.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ready = 1'b0;
    logic [15:0] cnt;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    logic [15:0] cnt2;
    logic        redirect2 = 1'b0;
    logic        ready2 = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int lat = 0;
    int wcnt = 0;

    logic [31:0] qpc[$];
    logic [31:0] qin[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata),
        .if_valid_o(valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
        .id_ready_i(ready), .fetch_cnt_o(cnt)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect2), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(ack2), .imem_rdata_i(rdata2),
        .if_valid_o(valid2), .if_pc_o(if_pc2), .if_instr_o(if_instr2),
        .id_ready_i(ready2), .fetch_cnt_o(cnt2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h2008_0005;
            32'h4:   mem = 32'h2009_000A;
            32'h8:   mem = 32'h0109_5020;
            default: mem = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0;
            wcnt = 0;
        end else if (ack) begin
            ack = 1'b0;
            wcnt = 0;
        end else if (req) begin
            if (wcnt >= lat) begin
                ack = 1'b1;
                rdata = mem(addr);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || ack2) begin
            ack2 = 1'b0;
        end else if (req2) begin
            ack2 = 1'b1;
            rdata2 = mem(addr2);
            q2.push_back(addr2);
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            qpc.push_back(if_pc);
            qin.push_back(if_instr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int n, input string tag);
        int k = 0;
        while (qpc.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 32'(qpc.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!valid && k < 100) begin
            tick();
            k++;
        end
        check(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        // reset values
        tick();
        tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_cnt", 32'(cnt), 32'd0);

        // 1: streaming with zero-wait memory
        ready = 1'b1;
        q2.delete();
        rst_n = 1'b1;
        wait_q(3, "t1_timeout");
        check("t1_cnt", 32'(cnt), 32'd3);
        if (qpc.size() >= 3) begin
            check("t1_pc0", qpc[0], 32'h0);
            check("t1_in0", qin[0], 32'h2008_0005);
            check("t1_pc1", qpc[1], 32'h4);
            check("t1_in1", qin[1], 32'h2009_000A);
            check("t1_pc2", qpc[2], 32'h8);
            check("t1_in2", qin[2], 32'h0109_5020);
        end
        check("t5_wrap_n", 32'(q2.size() >= 2), 32'd1);
        if (q2.size() >= 2) begin
            check("t5_wrap_a0", q2[0], 32'hFFFF_FFFC);
            check("t5_wrap_a1", q2[1], 32'h0);
        end

        // 2: decode stall holds the presented instruction
        ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_valid("t2_valid_to");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid", 32'(valid), 32'd1);
            check("t2_pc", if_pc, 32'h0);
            check("t2_instr", if_instr, 32'h2008_0005);
            check("t2_req", 32'(req), 32'd0);
        end
        ready = 1'b1;
        tick();
        check("t2_req_after", 32'(req), 32'd1);
        check("t2_addr_after", addr, 32'h4);
        check("t2_cnt", 32'(cnt), 32'd1);
        ready = 1'b0;

        // 3: redirect in HOLD
        tick();
        check("t3_hold_valid", 32'(valid), 32'd1);
        check("t3_hold_pc", if_pc, 32'h4);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t3_valid_clr", 32'(valid), 32'd0);
        check("t3_req", 32'(req), 32'd1);
        check("t3_addr", addr, 32'h40);
        qpc.delete();
        qin.delete();
        ready = 1'b1;
        wait_q(1, "t3_timeout");
        if (qpc.size() >= 1) begin
            check("t3_pc", qpc[0], 32'h40);
            check("t3_in", qin[0], mem(32'h40));
        end
        ready = 1'b0;

        // 4: redirect while a slow access is outstanding
        rst_n = 1'b0;
        lat = 2;
        tick();
        rst_n = 1'b1;
        tick();
        check("t4_req0", 32'(req), 32'd1);
        check("t4_addr0", addr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        check("t4_drop_req", 32'(req), 32'd1);
        check("t4_drop_addr", addr, 32'h0);
        tick();
        check("t4_drop_addr2", addr, 32'h0);
        check("t4_drop_valid", 32'(valid), 32'd0);
        tick();
        check("t4_new_req", 32'(req), 32'd1);
        check("t4_new_addr", addr, 32'h80);
        check("t4_new_valid", 32'(valid), 32'd0);
        qpc.delete();
        qin.delete();
        ready = 1'b1;
        wait_q(1, "t4_timeout");
        if (qpc.size() >= 1) begin
            check("t4_pc", qpc[0], 32'h80);
            check("t4_in", qin[0], mem(32'h80));
        end
        ready = 1'b0;

        // 5: unaligned target, then redirect coincident with ack
        rst_n = 1'b0;
        lat = 0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_hold", 32'(valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h43;
        tick();
        check("t5_align_addr", addr, 32'h40);
        check("t5_align_valid", 32'(valid), 32'd0);
        redirect_pc = 32'h106;
        tick();
        redirect = 1'b0;
        check("t5_ackredir_addr", addr, 32'h104);
        check("t5_ackredir_req", 32'(req), 32'd1);
        check("t5_ackredir_valid", 32'(valid), 32'd0);
        qpc.delete();
        qin.delete();
        ready = 1'b1;
        wait_q(1, "t5_timeout");
        check("t5_cnt", 32'(cnt), 32'd1);
        if (qpc.size() >= 1) begin
            check("t5_pc", qpc[0], 32'h104);
            check("t5_in", qin[0], mem(32'h104));
        end

        // 6: async reset with an access outstanding
        lat = 2;
        check("t6_req_pre", 32'(req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(req), 32'd0);
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_cnt", 32'(cnt), 32'd0);
        check("t6_addr", addr, 32'h0);
        lat = 0;
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_req_post", 32'(req), 32'd1);
        check("t6_addr_post", addr, 32'h0);
        check("t6_cnt_post", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
